// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Holds a 10-bit PC and a one-entry output buffer (instr, instr_pc, instr_valid).
// Fetch starts at PC 0 on start. Execute can redirect fetch with br_taken,
// and the dne word (9'h1FF) halts fetching.
// Optional feature macro: FETCH_STALL_CNT_EN enables the saturating stall_cnt
// counter. When the macro is undefined, stall_cnt is tied to zero.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [9:0]  imem_addr,
    input  logic [8:0]  imem_data,
    output logic [8:0]  instr,
    output logic [9:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [9:0]  br_target,
    output logic        done,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [8:0] DNE_WORD = 9'h1FF;

    state_t      state, state_nxt;
    logic [9:0]  pc, pc_nxt;
    logic        vld_nxt;
    logic        load;
    logic        buf_free;

    assign imem_addr = pc;
    assign done      = (state == HALT);
    assign buf_free  = ~instr_valid | instr_ready;

    // Next-state, next-PC and buffer-control decode; a redirect always beats a load.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        vld_nxt   = instr_valid;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = 10'd0;
                end
            end
            RUN: begin
                if (br_taken) begin
                    vld_nxt = 1'b0;
                    pc_nxt  = br_target;
                end else if (buf_free) begin
                    load    = 1'b1;
                    vld_nxt = 1'b1;
                    if (imem_data == DNE_WORD) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = pc + 10'd1;
                    end
                end
            end
            HALT: begin
                if (br_taken) begin
                    vld_nxt   = 1'b0;
                    pc_nxt    = br_target;
                    state_nxt = RUN;
                end else if (instr_valid && instr_ready) begin
                    vld_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, PC and output buffer registers; buffer data changes only on a load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= 10'd0;
            instr       <= 9'd0;
            instr_pc    <= 10'd0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_valid <= vld_nxt;
            if (load) begin
                instr    <= imem_data;
                instr_pc <= pc;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count cycles where decode back-pressures a valid word; saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (instr_valid && !instr_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; highest priority.
REQ-003 start  input  1  begins fetching at PC 0 when sampled high in IDLE.
REQ-004 imem_addr  output  10  instruction memory address (current PC).
REQ-005 imem_data  input  9  combinational memory read data for imem_addr, same cycle.
REQ-006 instr  output  9  buffered instruction to decode: [8:4] opcode, [3:0] operand/register/function.
REQ-007 instr_pc  output  10  PC of the word held in instr.
REQ-008 instr_valid  output  1  instr holds an undelivered instruction.
REQ-009 instr_ready  input  1  decode accepts instr this cycle when instr_valid is high.
REQ-010 br_taken  input  1  redirect request from execute (jizr/jnzr/bizr/bnzr/jtsr/lookup jumps).
REQ-011 br_target  input  10  redirect destination PC.
REQ-012 done  output  1  high while in HALT.
REQ-013 stall_cnt  output  16  count of cycles with instr_valid and not instr_ready.

Function
REQ-014 States: IDLE, RUN, HALT; the implementation SHALL hold a 10-bit PC and a one-entry output buffer (instr, instr_pc, instr_valid).
REQ-015 IDLE: start high -> RUN with PC=0; all other inputs ignored.
REQ-016 imem_addr SHALL equal PC at all times.
REQ-017 Buffer free = ~instr_valid, or instr_valid & instr_ready.
REQ-018 RUN, buffer free, no br_taken: instr<=imem_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
REQ-019 RUN, buffer not free: buffer and PC hold unchanged.
REQ-020 RUN, buffer free, instr_ready low, no load possible: not applicable; a free buffer always loads in RUN.
REQ-021 Accept with no reload (HALT, or br_taken): instr_valid<=0.
REQ-022 Latency: start sampled at edge N -> instr_valid high with instr_pc=0 after edge N+1; sustained throughput one word/cycle with instr_ready held high.
REQ-023 PC increment SHALL wrap 1023 -> 0 without error.
REQ-024 Loaded word 9'b11111_1111 (func dne): word is buffered as normal, PC not incremented, state -> HALT.
REQ-025 HALT: no further loads; buffered dne stays valid until accepted, then instr_valid<=0; done=1.
REQ-026 br_taken in RUN or HALT: instr_valid<=0 (buffer squashed, even if instr_ready high), PC<=br_target, state->RUN, no load that cycle; first target word valid after the following edge.
REQ-027 br_taken coincident with a dne load: redirect wins, no HALT entry.
REQ-028 br_taken in IDLE SHALL be ignored.
REQ-029 instr, instr_pc SHALL hold value whenever instr_valid is high and instr_ready is low.

Reset
REQ-030 reset high at an edge: state=IDLE, PC=0, instr=0, instr_pc=0, instr_valid=0, done=0, stall_cnt=0, regardless of any other input, including mid-operation and in HALT.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN defined: stall_cnt increments by 1 each cycle with instr_valid & ~instr_ready, saturating at 16'hFFFF; cleared only by reset.
REQ-032 Macro FETCH_STALL_CNT_EN undefined: stall_cnt tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-033 Memory 0:9'h000,1:9'h012,2:9'h1FF; reset, start one cycle, instr_ready=1 -> instr/instr_pc 000/0, 012/1, 1FF/2 on consecutive cycles; done=1 after the 1FF load; no further instr_valid pulses after 1FF accepted.
REQ-034 instr_ready low 3 cycles while instr_pc=1 -> instr, instr_pc, and PC frozen; stall_cnt +3 with FETCH_STALL_CNT_EN defined, 0 without.
REQ-035 br_taken=1, br_target=10'h200 while buffer holds instr_pc=5 -> next cycle instr_valid=0; following cycle instr_pc=10'h200.
REQ-036 br_taken in the cycle a dne word loads -> state RUN, done stays 0, fetch resumes at br_target.
REQ-037 Redirect to 10'h3FF, instr_ready=1 -> instr_pc sequence 3FF, 000, 001.
REQ-038 reset asserted in HALT and in RUN mid-stall -> all outputs at REQ-030 values next cycle; start required to resume at PC 0.
